dec_mult_normalizer: RTL

- Stage directly downstream of the exponent adder in the decimal32 multiplier. It consumes the 14-digit BCD coefficient product, together with the biased exponent sum and its carry/underflow indications.
- It normalizes the coefficient to 7 digits with a one-digit-per-cycle shift FSM, rounds half-to-even, and range-checks the exponent against decimal32 limits (bias 101, biased range 0..191).
- It produces the packed-ready sign/coefficient/exponent plus exception flags over a valid/ready handshake.

---
 rtl/dec_mult_normalizer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dec_mult_normalizer.sv
// Decimal32 multiplier back end: normalizes the 14-digit BCD product to 7 digits,
// rounds half-to-even, range-checks the exponent and hands the result over valid/ready.
module dec_mult_normalizer #(
  parameter int P_DIGITS    = 7,
  parameter int IN_DIGITS   = 14,
  parameter int EMAX_BIASED = 191
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [4*IN_DIGITS-1:0]  in_coeff,
  input  logic [7:0]              in_exp,
  input  logic                    in_exp_carry,
  input  logic                    in_exp_underflow,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic [4*P_DIGITS-1:0]   out_coeff,
  output logic [7:0]              out_exp,
  output logic                    out_overflow,
  output logic                    out_underflow,
  output logic                    out_inexact
);

  // One bit wider than the 10-bit source exponent so carry+255 plus all shifts cannot wrap.
  localparam int EW = 11;
  localparam logic signed [EW-1:0] L_EMAX   = EW'(EMAX_BIASED);
  localparam logic [4:0]           L_MAXSH  = 5'(IN_DIGITS);
  localparam logic [4*P_DIGITS-1:0] L_ALL9  = {P_DIGITS{4'h9}};
  localparam logic [4*P_DIGITS-1:0] L_POW   = {4'h1, {(4*(P_DIGITS-1)){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_ROUND, S_PACK, S_DONE} state_t;

  state_t                    r_state;
  logic [4*IN_DIGITS-1:0]    r_coeff;
  logic signed [EW-1:0]      r_exp;
  logic                      r_sign;
  logic [3:0]                r_guard;
  logic                      r_sticky;
  logic                      r_tiny;
  logic                      r_inexact;
  logic [4:0]                r_nshift;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_out_sign;
  logic [4*P_DIGITS-1:0]     r_out_coeff;
  logic [7:0]                r_out_exp;
  logic                      r_out_ov;
  logic                      r_out_uf;
  logic                      r_out_inx;

  logic                      w_upper_nz;
  logic                      w_coeff_nz;
  logic                      w_exp_neg;
  logic                      w_shift;
  logic signed [EW-1:0]      w_exp_in;
  logic [4*P_DIGITS-1:0]     w_inc;
  logic                      w_inc_c;
  logic                      w_round_up;

  assign w_upper_nz = |r_coeff[4*IN_DIGITS-1:4*P_DIGITS];
  assign w_coeff_nz = |r_coeff;
  assign w_exp_neg  = r_exp < 0;
  assign w_shift    = (w_upper_nz || (w_exp_neg && w_coeff_nz)) && (r_nshift < L_MAXSH);

  // Underflowed sum is in_exp - 256, which in two's complement is just 1s above bit 7.
  assign w_exp_in = in_exp_underflow ? {3'b111, in_exp} : {2'b00, in_exp_carry, in_exp};

  assign w_round_up = (r_guard > 4'd5) ||
                      ((r_guard == 4'd5) && (r_sticky || r_coeff[0]));

  always_comb begin
    w_inc   = r_coeff[4*P_DIGITS-1:0];
    w_inc_c = 1'b1;
    for (int unsigned i = 0; i < P_DIGITS; i++) begin
      if (w_inc_c) begin
        if (w_inc[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = w_inc[4*i +: 4] + 4'd1;
          w_inc_c         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_coeff     <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_guard     <= '0;
      r_sticky    <= 1'b0;
      r_tiny      <= 1'b0;
      r_inexact   <= 1'b0;
      r_nshift    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_coeff <= '0;
      r_out_exp   <= '0;
      r_out_ov    <= 1'b0;
      r_out_uf    <= 1'b0;
      r_out_inx   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sign     <= in_sign;
            r_coeff    <= in_coeff;
            r_exp      <= w_exp_in;
            r_guard    <= '0;
            r_sticky   <= 1'b0;
            r_tiny     <= 1'b0;
            r_nshift   <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_shift) begin
            r_coeff  <= {4'h0, r_coeff[4*IN_DIGITS-1:4]};
            r_guard  <= r_coeff[3:0];
            r_sticky <= r_sticky | (r_guard != 4'd0);
            r_tiny   <= r_tiny | w_exp_neg;
            r_exp    <= r_exp + 11'sd1;
            r_nshift <= r_nshift + 5'd1;
          end else begin
            if (!w_coeff_nz && w_exp_neg) r_exp <= '0;
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (w_round_up) begin
            if (w_inc_c) begin
              r_coeff <= {{(4*(IN_DIGITS-P_DIGITS)){1'b0}}, L_POW};
              r_exp   <= r_exp + 11'sd1;
            end else begin
              r_coeff <= {{(4*(IN_DIGITS-P_DIGITS)){1'b0}}, w_inc};
            end
          end
          r_inexact <= (r_guard != 4'd0) || r_sticky;
          r_state   <= S_PACK;
        end
        S_PACK: begin
          r_out_sign <= r_sign;
          if (r_exp > L_EMAX) begin
            r_out_ov    <= 1'b1;
            r_out_uf    <= 1'b0;
            r_out_coeff <= L_ALL9;
            r_out_exp   <= 8'(EMAX_BIASED);
            r_out_inx   <= 1'b1;
          end else begin
            r_out_ov    <= 1'b0;
            r_out_uf    <= r_tiny && r_inexact;
            r_out_coeff <= r_coeff[4*P_DIGITS-1:0];
            r_out_exp   <= r_exp[7:0];
            r_out_inx   <= r_inexact;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_sign      = r_out_sign;
  assign out_coeff     = r_out_coeff;
  assign out_exp       = r_out_exp;
  assign out_overflow  = r_out_ov;
  assign out_underflow = r_out_uf;
  assign out_inexact   = r_out_inx;

endmodule
